// File: rtl/user_ram_pkg.sv
// Shared types and helpers for the user RAM controller: FSM states,
// default window base and the read-modify-write byte merge.
package user_ram_pkg;

    localparam logic [31:0] USER_RAM_BASE = 32'h0300_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_ACK
    } state_e;

    // Strobed bytes come from the CPU, the rest from the word read back.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] wdata,
        input logic [31:0] old,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/user_ram_ctrl.sv
// CPU-bus to single-port synchronous RAM bridge. Full-word writes go straight
// to the RAM; partial writes do a read-modify-write through the capture state.
module user_ram_ctrl
    import user_ram_pkg::*;
#(
    parameter int          ADDR_BIT  = 8,
    parameter logic [31:0] BASE_ADDR = USER_RAM_BASE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_valid_i,
    input  logic [31:0]         mem_addr_i,
    input  logic [31:0]         mem_wdata_i,
    input  logic [3:0]          mem_wstrb_i,
    output logic                mem_ready_o,
    output logic [31:0]         mem_rdata_o,
    output logic                ram_wr_en_o,
    output logic                ram_rd_en_o,
    output logic [ADDR_BIT-1:0] ram_addr_o,
    output logic [31:0]         ram_di_o,
    input  logic [31:0]         ram_do_i
);

    localparam int TAG_LSB = ADDR_BIT + 2;

    state_e              state_q, state_d;
    logic [ADDR_BIT-1:0] addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                rmw_q, rmw_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         di_q, di_d;
    logic                ready_q, rd_en_q, wr_en_q;
    logic                sel;
    logic                unused_addr_bits;

    // Byte offset within the word carries no information for this block.
    assign unused_addr_bits = ^mem_addr_i[1:0];

    assign sel = (mem_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rmw_d   = rmw_q;
        rdata_d = rdata_q;
        di_d    = di_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid_i && sel) begin
                    addr_d  = mem_addr_i[TAG_LSB-1:2];
                    wdata_d = mem_wdata_i;
                    wstrb_d = mem_wstrb_i;
                    if (mem_wstrb_i == 4'hF) begin
                        rmw_d   = 1'b0;
                        di_d    = mem_wdata_i;
                        state_d = ST_WR;
                    end else begin
                        rmw_d   = (mem_wstrb_i != 4'h0);
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_CAP;
            ST_CAP: begin
                // ram_do_i is valid here, one cycle after the read enable.
                if (rmw_q) begin
                    di_d    = merge_bytes(wdata_q, ram_do_i, wstrb_q);
                    state_d = ST_WR;
                end else begin
                    rdata_d = ram_do_i;
                    state_d = ST_ACK;
                end
            end
            ST_WR:   state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free and
    // line up exactly with the RD/WR/ACK cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rmw_q   <= 1'b0;
            rdata_q <= '0;
            di_q    <= '0;
            ready_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rmw_q   <= rmw_d;
            rdata_q <= rdata_d;
            di_q    <= di_d;
            ready_q <= (state_d == ST_ACK);
            rd_en_q <= (state_d == ST_RD);
            wr_en_q <= (state_d == ST_WR);
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign ram_rd_en_o = rd_en_q;
    assign ram_wr_en_o = wr_en_q;
    assign ram_addr_o  = addr_q;
    assign ram_di_o    = di_q;

endmodule
